// File: rtl/led_pkg.sv
// Shared types and elaboration helpers for the LED pattern generator family.
package led_pkg;

  typedef enum logic [2:0] {
    LED_OFF    = 3'd0,
    LED_ON     = 3'd1,
    LED_BLINK  = 3'd2,
    LED_ALT    = 3'd3,
    LED_CHASE  = 3'd4,
    LED_BOUNCE = 3'd5
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } led_dir_e;

  localparam int unsigned SPEED_W    = 2;
  localparam int unsigned STEP_CNT_W = 3;  // holds 2**(2**SPEED_W - 1) - 1

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, first tick on the
// DIV-th cycle after reset release.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick    = (count_q == CW'(DIV - 1));
  assign count_d = tick ? '0 : count_q + CW'(1);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern engine with step prescaling and a global PWM
// brightness gate; outputs are registered for direct pin drive.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_HZ  = 2,
  parameter int unsigned N_LEDS   = 4,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          mode,
  input  logic [SPEED_W-1:0]  speed,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   led,
  output logic                tick_o
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned POS_W    = cnt_width(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

  logic tick;

  led_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign tick_o = tick;

  logic [2:0]            mode_q, mode_d;
  logic                  phase_q, phase_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  led_dir_e              dir_q, dir_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  pwm_on_q, pwm_on_d;
  logic [N_LEDS-1:0]     led_q, led_d;

  logic                  mode_chg;
  logic                  step_en;
  logic [STEP_CNT_W-1:0] step_thr;
  logic [STEP_CNT_W-1:0] all_ones;
  logic [N_LEDS-1:0]     pat;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= LED_OFF;
      phase_q    <= 1'b0;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      pwm_on_q   <= 1'b0;
      led_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_on_q   <= pwm_on_d;
      led_q      <= led_d;
    end
  end

  // Threshold 2**speed - 1; the >= compare lets a lowered speed step at once.
  assign all_ones = '1;
  assign step_thr = ~(all_ones << speed);
  assign mode_chg = (mode != mode_q);
  assign step_en  = tick && (step_cnt_q >= step_thr);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    mode_d     = mode_q;
    phase_d    = phase_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    step_cnt_d = step_cnt_q;

    if (mode_chg) begin
      // A step landing on a mode change is dropped along with the old state.
      mode_d     = mode;
      phase_d    = 1'b0;
      pos_d      = '0;
      dir_d      = DIR_UP;
      step_cnt_d = '0;
    end else if (step_en) begin
      step_cnt_d = '0;
      phase_d    = ~phase_q;
      if (N_LEDS > 1) begin
        case (mode_q)
          LED_CHASE: begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
          end
          LED_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                dir_d = DIR_DOWN;
                pos_d = pos_q - POS_W'(1);
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = pos_q + POS_W'(1);
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end else if (tick) begin
      step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
    end
  end

  always_comb begin
    pat = '0;
    case (mode_q)
      LED_ON:    pat = '1;
      LED_BLINK: pat = {N_LEDS{phase_q}};
      LED_ALT: begin
        for (int i = 0; i < N_LEDS; i++) begin
          pat[i] = (i % 2 == 0) ? phase_q : ~phase_q;
        end
      end
      LED_CHASE, LED_BOUNCE: pat = N_LEDS'(1) << pos_q;
      default:   pat = '0;
    endcase
  end

  // Brightness is registered into pwm_on_q so it shares the mode path latency.
  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  assign pwm_on_d  = (brightness == '1) || (pwm_cnt_q < brightness);
  assign led_d     = pat & {N_LEDS{pwm_on_q}};
  assign led       = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench: per-cycle scoreboard against a step-count model plus
// hand-derived sequences for the pattern, PWM, mode-change and reset cases.
module tb_led_pattern_gen;
  import led_pkg::*;

  localparam int unsigned CLK_HZ   = 100;
  localparam int unsigned TICK_HZ  = 10;
  localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
  localparam int unsigned N        = 4;
  localparam int unsigned PWM_BITS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    mode;
  logic [1:0]    speed;
  logic [3:0]    brightness;
  logic [N-1:0]  led;
  logic          tick_o;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .N_LEDS   (N),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .speed      (speed),
    .brightness (brightness),
    .led        (led),
    .tick_o     (tick_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [N-1:0] led;
    logic         tick;
  } exp_t;

  exp_t sb_q[$];

  int           m_pre, m_sc, m_steps;
  logic [2:0]   m_mode;
  int           m_pwm;
  logic         m_pwm_on;
  logic [N-1:0] m_led;

  // Pattern as a function of steps taken since the mode was loaded.
  function automatic logic [N-1:0] model_pat(input logic [2:0] md, input int steps);
    int r;
    logic ph;
    ph = (steps % 2) == 1;
    r  = steps % (2 * N - 2);
    case (md)
      3'd1:    return 4'b1111;
      3'd2:    return ph ? 4'b1111 : 4'b0000;
      3'd3:    return ph ? 4'b0101 : 4'b1010;
      3'd4:    return 4'b0001 << (steps % N);
      3'd5:    return 4'b0001 << ((r <= N - 1) ? r : (2 * N - 2) - r);
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_step();
    logic m_tick;
    if (rst) begin
      m_pre = 0; m_sc = 0; m_steps = 0; m_mode = 3'd0;
      m_pwm = 0; m_pwm_on = 1'b0; m_led = '0;
    end else begin
      m_tick   = (m_pre == DIV - 1);
      m_led    = model_pat(m_mode, m_steps) & {N{m_pwm_on}};
      m_pwm_on = (brightness == 4'hF) || (m_pwm < int'(brightness));
      m_pwm    = (m_pwm + 1) % 16;
      m_pre    = m_tick ? 0 : m_pre + 1;
      if (mode != m_mode) begin
        m_mode = mode; m_steps = 0; m_sc = 0;
      end else if (m_tick) begin
        if (m_sc >= (1 << speed) - 1) begin
          m_sc = 0; m_steps++;
        end else begin
          m_sc++;
        end
      end
    end
    sb_q.push_back('{led: m_led, tick: (m_pre == DIV - 1)});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_led", led, e.led);
      check("sb_tick", tick_o, e.tick);
    end else begin
      check("sb_depth", sb_q.size(), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      @(negedge clk);
      if (tick_o === 1'b1) seen = 1'b1;
    end
    check("tick_seen", seen, 1);
  endtask

  // Load new inputs just after a tick, return once the new mode shows on led.
  task automatic apply(input logic [2:0] md, input logic [1:0] sp, input logic [3:0] br);
    wait_tick();
    @(posedge clk);
    #1;
    mode = md; speed = sp; brightness = br;
    repeat (3) @(negedge clk);
  endtask

  // Return once the step caused by the n-th tick is visible on led.
  task automatic step_wait(input int n);
    for (int i = 0; i < n; i++) wait_tick();
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    string        name;
    logic [2:0]   mode;
    logic [1:0]   speed;
    logic [3:0]   bright;
    logic [N-1:0] exp_led;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int on_cnt;
    logic [N-1:0] bounce_exp [7];
    logic [N-1:0] chase_exp  [4];

    vecs[0] = '{"v_on",      3'd1, 2'd0, 4'hF, 4'b1111};
    vecs[1] = '{"v_off",     3'd0, 2'd0, 4'hF, 4'b0000};
    vecs[2] = '{"v_blink",   3'd2, 2'd0, 4'hF, 4'b0000};
    vecs[3] = '{"v_alt",     3'd3, 2'd0, 4'hF, 4'b1010};
    vecs[4] = '{"v_chase",   3'd4, 2'd0, 4'hF, 4'b0001};
    vecs[5] = '{"v_bounce",  3'd5, 2'd0, 4'hF, 4'b0001};
    vecs[6] = '{"v_rsvd6",   3'd6, 2'd0, 4'hF, 4'b0000};
    vecs[7] = '{"v_rsvd7",   3'd7, 2'd0, 4'hF, 4'b0000};
    vecs[8] = '{"v_on_dark", 3'd1, 2'd0, 4'h0, 4'b0000};

    bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    chase_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset and prescaler
    rst = 1'b1; mode = 3'd0; speed = 2'd0; brightness = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", led, 4'b0000);
    check("rst_tick", tick_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      check("presc_tick", tick_o, (i % 10 == 0));
      check("presc_led", led, 4'b0000);
    end

    // Steady state right after each mode load
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].mode, vecs[i].speed, vecs[i].bright);
      check(vecs[i].name, led, vecs[i].exp_led);
    end

    // ALT strictly alternates
    apply(3'd3, 2'd0, 4'hF);
    check("alt_0", led, 4'b1010);
    step_wait(1); check("alt_1", led, 4'b0101);
    step_wait(1); check("alt_2", led, 4'b1010);
    step_wait(1); check("alt_3", led, 4'b0101);

    // CHASE at speed 1: one step per two ticks, wraps
    apply(3'd4, 2'd1, 4'hF);
    check("chase_p0", led, 4'b0001);
    step_wait(1); check("chase_half", led, 4'b0001);
    step_wait(1); check("chase_s1", led, chase_exp[0]);
    for (int i = 1; i < 4; i++) begin
      step_wait(2);
      check("chase_seq", led, chase_exp[i]);
    end

    // BOUNCE at speed 0: 0,1,2,3,2,1,0,1
    apply(3'd5, 2'd0, 4'hF);
    check("bounce_p0", led, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      step_wait(1);
      check("bounce_seq", led, bounce_exp[i]);
    end

    // PWM duty
    apply(3'd1, 2'd0, 4'h4);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led == 4'b1111) on_cnt++;
      check("pwm4_level", (led == 4'b1111) || (led == 4'b0000), 1);
    end
    check("pwm4_duty", on_cnt, 4);
    @(posedge clk); #1 brightness = 4'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("pwm0_dark", led, 4'b0000);
    end
    @(posedge clk); #1 brightness = 4'hF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("pwmF_full", led, 4'b1111);
    end

    // Mode change coinciding with a tick discards that step
    apply(3'd4, 2'd0, 4'hF);
    step_wait(2);
    check("chg_pos2", led, 4'b0100);
    wait_tick();
    mode = 3'd2;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("chg_blink_dark", led, 4'b0000);
    end
    step_wait(1);
    check("chg_blink_on", led, 4'b1111);

    // Reset in the middle of BOUNCE
    apply(3'd5, 2'd0, 4'hF);
    step_wait(2);
    check("rstmid_pos2", led, 4'b0100);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmid_led", led, 4'b0000);
    check("rstmid_tick", tick_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_pos0", led, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
